mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
Moore-style main controller for the multi-cycle MIPS datapath. It sequences a single shared ALU, register file and unified instruction/data memory across fetch, decode, execute, memory and write-back steps. It produces the 3-bit ALUOp consumed by the existing ALU control decoder, plus all datapath mux and enable strobes. It handshakes with memory through a ready signal.

Parameters:
MEM_WAIT_MAX, 15, cycles to wait for mem_ready_i before flagging a memory timeout (0 disables the timeout).

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
op_i  input  6  opcode field of the instruction register
zero_i  input  1  ALU zero flag
mem_ready_i  input  1  memory access completes this cycle
pc_write_o  output  1  PC load enable
pc_src_o  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
ir_write_o  output  1  instruction register load enable
iord_o  output  1  memory address source: 0 PC, 1 ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
reg_write_o  output  1  register-file write enable
reg_dst_o  output  1  destination register: 0 rt, 1 rd
mem_to_reg_o  output  1  write-back source: 0 ALUOut, 1 MDR
alu_src_a_o  output  1  ALU A input: 0 PC, 1 rs
alu_src_b_o  output  2  ALU B input: 00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
ALUOp_o  output  3  000 add, 001 sub, 010 or, 100 R-type (funct decode)
instr_done_o  output  1  one-cycle pulse when an instruction retires
illegal_o  output  1  sticky flag: unsupported opcode or memory timeout

Behaviour:
- Reset (rst_i low): state is IDLE immediately, asynchronously. All outputs are 0, op_q is 0 and the wait counter is 0. Outputs drop within the same cycle, including mid-access (mem_read_o, mem_write_o).
- State register: 4 bits. Outputs decode from state only, except the strobes gated by mem_ready_i or zero_i noted below.
- IDLE: all outputs 0. Next state FETCH.
- FETCH:
  - Drives mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, ALUOp_o=000, pc_src_o=00.
  - ir_write_o and pc_write_o equal mem_ready_i.
  - Stays in FETCH until mem_ready_i=1, then goes to DECODE.
- DECODE:
  - Latches op_i into op_q.
  - Drives alu_src_a_o=0, alu_src_b_o=11, ALUOp_o=000 (branch target is computed into ALUOut).
  - Next state by op_i:
    - 000000 → R_EXEC
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 or 001101 → I_EXEC
    - anything else → TRAP
- MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, ALUOp_o=000. Next MEM_RD if op_q is lw, else MEM_WR.
- MEM_RD: mem_read_o=1, iord_o=1. Waits for mem_ready_i, then MEM_WB.
- MEM_WB: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0, instr_done_o=1. Next FETCH.
- MEM_WR: mem_write_o=1, iord_o=1. Waits for mem_ready_i; on that cycle instr_done_o=1, next FETCH.
- R_EXEC: alu_src_a_o=1, alu_src_b_o=00, ALUOp_o=100. Next R_WB.
- R_WB: reg_write_o=1, reg_dst_o=1, instr_done_o=1. Next FETCH.
- BRANCH: alu_src_a_o=1, alu_src_b_o=00, ALUOp_o=001, pc_src_o=01, pc_write_o=zero_i, instr_done_o=1. Next FETCH.
- JUMP: pc_write_o=1, pc_src_o=10, instr_done_o=1. Next FETCH.
- I_EXEC: alu_src_a_o=1, alu_src_b_o=10. ALUOp_o=000 for addi, 010 for ori. Next I_WB.
- I_WB: reg_write_o=1, reg_dst_o=0, instr_done_o=1. Next FETCH.
- TRAP: illegal_o=1, all other outputs 0. Stays in TRAP until reset.
- Wait counter (4 bits):
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i=0.
  - Clears on state change.
  - When it reaches MEM_WAIT_MAX (nonzero), the next state is TRAP.
- Latency with zero wait cycles: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi/ori 4.
- mem_ready_i is ignored in every state that is not FETCH, MEM_RD or MEM_WR.

Optional Feature:
MC_PERF_CNT_EN
- Defined: adds outputs cycle_cnt_o[31:0] and retire_cnt_o[31:0].
  - cycle_cnt_o increments every cycle outside IDLE and TRAP.
  - retire_cnt_o increments on instr_done_o.
  - Both wrap at 2^32 and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI);
  - the state enum (IDLE..TRAP);
  - ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_OR, ALUOP_RTYPE);
  - the mux select codes.
- One sub-module, mc_ctrl_outdec: a combinational state-to-output decoder, keeping the FSM file limited to next-state and counter logic.

Test Plan:
- Reset released, mem_ready_i=1, op_i=000000, zero_i=0 → IDLE, FETCH, DECODE, R_EXEC (ALUOp_o=100), R_WB (reg_write_o=1, reg_dst_o=1, instr_done_o=1); FETCH again on cycle 6.
- lw (op 100011), mem_ready_i low for 2 cycles in MEM_RD → mem_read_o=1 and iord_o=1 held 3 cycles; then MEM_WB with mem_to_reg_o=1; 7 cycles FETCH-to-FETCH.
- beq (op 000100), zero_i=1 → BRANCH drives ALUOp_o=001, pc_src_o=01, pc_write_o=1; repeated with zero_i=0 → pc_write_o=0.
- ori (op 001101) → I_EXEC drives ALUOp_o=010, alu_src_b_o=10; I_WB drives reg_write_o=1, reg_dst_o=0.
- op_i=111111 in DECODE → TRAP next cycle, illegal_o=1 held for 20 cycles; mem_ready_i=0 for 15 cycles in FETCH (MEM_WAIT_MAX=15) → TRAP.
- rst_i pulled low mid MEM_WR → mem_write_o=0 in the same cycle, state IDLE; after release FETCH resumes (retire_cnt_o=0 with MC_PERF_CNT_EN).

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main controller:
// opcodes, FSM state encoding, ALUOp codes and datapath mux selects.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        R_EXEC,
        R_WB,
        BRANCH,
        JUMP,
        I_EXEC,
        I_WB,
        TRAP
    } state_e;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;

    localparam logic       REGDST_RT = 1'b0;
    localparam logic       REGDST_RD = 1'b1;

    localparam logic       WB_ALUOUT = 1'b0;
    localparam logic       WB_MDR    = 1'b1;

    // States that stall on the memory handshake
    function automatic logic is_mem_wait(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps controller state to datapath strobes.
// Only the handshake/branch strobes look at mem_ready_i and zero_i.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  op_q_i,
    input  logic        mem_ready_i,
    input  logic        zero_i,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        ir_write_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  ALUOp_o,
    output logic        instr_done_o,
    output logic        illegal_o
);

    // Decode per-state strobes; everything defaults inactive
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = PCSRC_ALU;
        ir_write_o   = 1'b0;
        iord_o       = IORD_PC;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = REGDST_RT;
        mem_to_reg_o = WB_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RT;
        ALUOp_o      = ALUOP_ADD;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        unique case (state_i)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            DECODE: begin
                alu_src_b_o = SRCB_IMMSH2;
            end
            MEM_ADDR: begin
                alu_src_a_o = SRCA_RS;
                alu_src_b_o = SRCB_IMM;
            end
            MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = IORD_ALUOUT;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = WB_MDR;
                instr_done_o = 1'b1;
            end
            MEM_WR: begin
                mem_write_o  = 1'b1;
                iord_o       = IORD_ALUOUT;
                instr_done_o = mem_ready_i;
            end
            R_EXEC: begin
                alu_src_a_o = SRCA_RS;
                ALUOp_o     = ALUOP_RTYPE;
            end
            R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REGDST_RD;
                instr_done_o = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o  = SRCA_RS;
                ALUOp_o      = ALUOP_SUB;
                pc_src_o     = PCSRC_ALUOUT;
                pc_write_o   = zero_i;
                instr_done_o = 1'b1;
            end
            JUMP: begin
                pc_write_o   = 1'b1;
                pc_src_o     = PCSRC_JUMP;
                instr_done_o = 1'b1;
            end
            I_EXEC: begin
                alu_src_a_o = SRCA_RS;
                alu_src_b_o = SRCB_IMM;
                ALUOp_o     = (op_q_i == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            I_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            TRAP: begin
                illegal_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main controller: next-state, opcode latch, memory
// wait timeout. Optional perf counters under `MC_PERF_CNT_EN`.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  op_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        ir_write_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  ALUOp_o,
    output logic        instr_done_o,
    output logic        illegal_o
`ifdef MC_PERF_CNT_EN
   ,output logic [31:0] cycle_cnt_o
   ,output logic [31:0] retire_cnt_o
`endif
);

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [3:0]  wait_q, wait_d;
    logic        wait_inc;

    // State, latched opcode and wait counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state sequencing plus memory-stall timeout into TRAP
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wait_inc = is_mem_wait(state_q) && !mem_ready_i;
        wait_d   = wait_inc ? wait_q + 4'd1 : wait_q;
        unique case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                op_d = op_i;
                unique case (op_i)
                    OP_RTYPE:       state_d = R_EXEC;
                    OP_LW, OP_SW:   state_d = MEM_ADDR;
                    OP_BEQ:         state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    OP_ADDI, OP_ORI: state_d = I_EXEC;
                    default:        state_d = TRAP;
                endcase
            end
            MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready_i) state_d = MEM_WB;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   if (mem_ready_i) state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            I_EXEC:   state_d = I_WB;
            I_WB:     state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = TRAP;
        endcase
        if ((MEM_WAIT_MAX != 0) && wait_inc && (wait_d == WAIT_MAX)) begin
            state_d = TRAP;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i      (state_q),
        .op_q_i       (op_q),
        .mem_ready_i  (mem_ready_i),
        .zero_i       (zero_i),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .ir_write_o   (ir_write_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .ALUOp_o      (ALUOp_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o)
    );

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;

    // Active-cycle and retired-instruction counters, wrapping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != IDLE && state_q != TRAP) cyc_q <= cyc_q + 32'd1;
            if (instr_done_o) ret_q <= ret_q + 32'd1;
        end
    end

    assign cycle_cnt_o  = cyc_q;
    assign retire_cnt_o = ret_q;
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: random instruction stream with
// random memory stalls, plus trap, timeout and mid-access reset cases.
module tb_mc_main_ctrl;
    import mc_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  op_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        ir_write_o;
    logic        iord_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        reg_write_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  ALUOp_o;
    logic        instr_done_o;
    logic        illegal_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_o;
    logic [31:0] retire_cnt_o;
`endif

    mc_main_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .ir_write_o   (ir_write_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .ALUOp_o      (ALUOp_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o)
`ifdef MC_PERF_CNT_EN
       ,.cycle_cnt_o  (cycle_cnt_o)
       ,.retire_cnt_o (retire_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int total_lat = 0;
    int n_ret = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    logic [17:0] vec;
    assign vec = {pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o,
                  mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                  alu_src_a_o, alu_src_b_o, ALUOp_o, instr_done_o,
                  illegal_o};

    typedef struct {
        int          ecyc;
        logic [17:0] prev;
        logic [17:0] cur;
    } rec_t;

    rec_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(
        input int pcw, input int pcs, input int irw, input int iord,
        input int mr, input int mw, input int rw, input int rd,
        input int m2r, input int a, input int b, input int alu,
        input int done, input int ill);
        return {1'(pcw), 2'(pcs), 1'(irw), 1'(iord), 1'(mr), 1'(mw),
                1'(rw), 1'(rd), 1'(m2r), 1'(a), 2'(b), 3'(alu),
                1'(done), 1'(ill)};
    endfunction

    function automatic int base_lat(input logic [5:0] op);
        case (op)
            OP_LW:         return 5;
            OP_BEQ, OP_J:  return 3;
            default:       return 4;
        endcase
    endfunction

    // Monitor: on each retirement pop expected timing and outputs
    logic [17:0] prev_vec = '0;
    rec_t        r;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_vec <= '0;
        end else begin
            if (instr_done_o) begin
                if (sb_q.size() == 0) begin
                    chk("retire_unexpected", int'(vec), 0);
                end else begin
                    r = sb_q.pop_front();
                    chk("retire_cycle", cyc, r.ecyc);
                    chk("retire_prev_outputs", int'(prev_vec), int'(r.prev));
                    chk("retire_outputs", int'(vec), int'(r.cur));
                end
            end
            prev_vec <= vec;
        end
    end

    // Drive one instruction; entered just after the edge into FETCH
    task automatic run_instr(input logic [5:0] op, input int wf,
                             input int wm, input logic z);
        int lat, c0, ms;
        logic mem_op;
        logic [17:0] ep, ec, dec_v;
        rec_t rr;
        mem_op = (op == OP_LW) || (op == OP_SW);
        lat = base_lat(op) + wf + (mem_op ? wm : 0);
        ms = wf + 3;
        dec_v = mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0);
        case (op)
            OP_RTYPE: begin
                ep = mk(0,0,0,0,0,0,0,0,0,1,0,4,0,0);
                ec = mk(0,0,0,0,0,0,1,1,0,0,0,0,1,0);
            end
            OP_LW: begin
                ep = mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0);
                ec = mk(0,0,0,0,0,0,1,0,1,0,0,0,1,0);
            end
            OP_SW: begin
                ep = (wm > 0) ? mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0)
                              : mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0);
                ec = mk(0,0,0,1,0,1,0,0,0,0,0,0,1,0);
            end
            OP_BEQ: begin
                ep = dec_v;
                ec = mk(int'(z),1,0,0,0,0,0,0,0,1,0,1,1,0);
            end
            OP_J: begin
                ep = dec_v;
                ec = mk(1,2,0,0,0,0,0,0,0,0,0,0,1,0);
            end
            default: begin
                ep = mk(0,0,0,0,0,0,0,0,0,1,2,(op == OP_ORI) ? 2 : 0,0,0);
                ec = mk(0,0,0,0,0,0,1,0,0,0,0,0,1,0);
            end
        endcase
        #1;
        c0 = cyc;
        rr.ecyc = c0 + lat - 1;
        rr.prev = ep;
        rr.cur  = ec;
        sb_q.push_back(rr);
        total_lat += lat;
        n_ret++;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) begin
                @(posedge clk_i);
                #1;
            end
            op_i   = op;
            zero_i = z;
            if (k <= wf)
                mem_ready_i = (k == wf);
            else if (mem_op && k >= ms && k <= ms + wm)
                mem_ready_i = (k == ms + wm);
            else
                mem_ready_i = 1'($urandom_range(0, 1));
        end
        @(posedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_outputs", int'(vec), 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
    endtask

    logic [5:0] ops [7];

    initial begin
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
        rst_i = 1'b0;
        op_i = '0;
        zero_i = 1'b0;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", int'(vec), 0);
`ifdef MC_PERF_CNT_EN
        chk("reset_retire_cnt", int'(retire_cnt_o), 0);
`endif
        rst_i = 1'b1;
        #1;
        chk("idle_outputs", int'(vec), 0);
        @(posedge clk_i);

        run_instr(OP_RTYPE, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 2, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 1, 0, 1'b0);
        run_instr(OP_ORI, 0, 0, 1'b0);
        run_instr(OP_SW, 2, 3, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_ADDI, 14, 0, 1'b0);
        run_instr(OP_LW, 3, 14, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run_instr(ops[$urandom_range(0, 6)],
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end
        #1;
`ifdef MC_PERF_CNT_EN
        chk("cycle_cnt", int'(cycle_cnt_o), total_lat);
        chk("retire_cnt", int'(retire_cnt_o), n_ret);
`endif
        @(negedge clk_i);
        chk("scoreboard_drained", sb_q.size(), 0);

        // Unsupported opcode traps and holds
        op_i = 6'h3f;
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("trap_hold", int'(vec), int'(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
            mem_ready_i = 1'($urandom_range(0, 1));
        end

        // Fetch stalled for MEM_WAIT_MAX cycles times out
        do_reset();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            chk("timeout_fetch_wait", int'({mem_read_o, illegal_o}), 2);
        end
        @(negedge clk_i);
        chk("timeout_trap", int'(illegal_o), 1);

        // Reset during a stalled store drops the write at once
        do_reset();
        #1;
        op_i = OP_SW;
        mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("memwr_active", int'({mem_write_o, iord_o}), 3);
        #2;
        rst_i = 1'b0;
        #1;
        chk("memwr_reset_drop", int'(mem_write_o), 0);
        chk("memwr_reset_outputs", int'(vec), 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("fetch_after_reset", int'({mem_read_o, iord_o}), 2);
`ifdef MC_PERF_CNT_EN
        chk("retire_cnt_after_reset", int'(retire_cnt_o), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
